// File: rtl/ir_nec_rx.sv
`timescale 1ns/1ps
// ir_nec_rx -- NEC infrared protocol receiver.
//
// Decodes a demodulated IR line (idle high, burst low) into 32-bit NEC
// frames and repeat codes by timing pulse widths with the system clock.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz, scales every timing window
//   TOL_PCT    symmetric tolerance in percent around every nominal width
//   CHECK_INV  1: reject frames whose command inverse byte is wrong
//   REPEAT_EN  1: recognise the 9 ms / 2.25 ms / 560 us repeat code
//
// Ports
//   clk           rising-edge system clock
//   reset_n       asynchronous active-low reset
//   iIR           raw asynchronous demodulated IR input
//   frame_valid   one-cycle pulse when a frame is accepted
//   repeat_pulse  one-cycle pulse when a repeat code is accepted
//   ir_addr       frame bits 15:0 of the last accepted frame
//   ir_data       frame bits 31:16 of the last accepted frame
//   err           one-cycle pulse when a frame is rejected
//   err_code      cause of the last err pulse (held):
//                 1 leader low, 2 leader high, 3 bit/stop timing,
//                 4 10 ms timeout, 5 command inverse, 6 repeat without frame
module ir_nec_rx #(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned TOL_PCT   = 25,
   parameter bit          CHECK_INV = 1'b1,
   parameter bit          REPEAT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        iIR,
   output logic        frame_valid,
   output logic        repeat_pulse,
   output logic [15:0] ir_addr,
   output logic [15:0] ir_data,
   output logic        err,
   output logic [2:0]  err_code
);

   localparam longint unsigned CNT_10MS = (64'(CLK_HZ) * 64'd10000) / 64'd1000000;
   localparam int unsigned     CW       = $clog2(CNT_10MS + 64'd1);

   function automatic logic [CW:0] win_bound(input longint unsigned us,
                                             input longint unsigned pct);
      longint unsigned n;
      n = (64'(CLK_HZ) * us) / 64'd1000000;
      return (CW+1)'((n * pct) / 64'd100);
   endfunction

   localparam longint unsigned PCT_LO = 64'(100 - TOL_PCT);
   localparam longint unsigned PCT_HI = 64'(100 + TOL_PCT);

   localparam logic [CW:0] LO_9000 = win_bound(64'd9000, PCT_LO);
   localparam logic [CW:0] HI_9000 = win_bound(64'd9000, PCT_HI);
   localparam logic [CW:0] LO_4500 = win_bound(64'd4500, PCT_LO);
   localparam logic [CW:0] HI_4500 = win_bound(64'd4500, PCT_HI);
   localparam logic [CW:0] LO_2250 = win_bound(64'd2250, PCT_LO);
   localparam logic [CW:0] HI_2250 = win_bound(64'd2250, PCT_HI);
   localparam logic [CW:0] LO_560  = win_bound(64'd560,  PCT_LO);
   localparam logic [CW:0] HI_560  = win_bound(64'd560,  PCT_HI);
   localparam logic [CW:0] LO_1690 = win_bound(64'd1690, PCT_LO);
   localparam logic [CW:0] HI_1690 = win_bound(64'd1690, PCT_HI);
   localparam logic [CW-1:0] CNT_MAX = CW'(CNT_10MS);

   function automatic logic in_win(input logic [CW:0] len,
                                   input logic [CW:0] lo,
                                   input logic [CW:0] hi);
      return (len > lo) && (len < hi);
   endfunction

   typedef enum logic [2:0] {
      IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP_LO
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_sync1, r_sync2, r_dly;
   logic [CW-1:0] r_cnt;
   logic [4:0]    r_idx;
   logic [31:0]   r_shift;
   logic          r_rpt, w_rpt_nxt;
   logic          r_last_ok;
   logic          r_frame_valid, r_repeat_pulse, r_err;
   logic [2:0]    r_err_code;
   logic [15:0]   r_addr, r_data;

   logic          w_nedge, w_pedge;
   logic [CW:0]   w_len;
   logic          w_w9000, w_w4500, w_w2250, w_w560, w_w1690;
   logic          w_clr_cnt, w_idx_clr, w_store, w_bit, w_load;
   logic          w_fv, w_rp, w_err;
   logic [2:0]    w_code;

   assign w_nedge = r_dly & ~r_sync2;
   assign w_pedge = ~r_dly & r_sync2;

   // r_cnt holds cycles since the last accepted edge minus one, so the
   // interval between two edge-detect cycles is r_cnt + 1.
   assign w_len   = {1'b0, r_cnt} + (CW+1)'(1);

   assign w_w9000 = in_win(w_len, LO_9000, HI_9000);
   assign w_w4500 = in_win(w_len, LO_4500, HI_4500);
   assign w_w2250 = in_win(w_len, LO_2250, HI_2250);
   assign w_w560  = in_win(w_len, LO_560,  HI_560);
   assign w_w1690 = in_win(w_len, LO_1690, HI_1690);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_dly   <= 1'b1;
      end else begin
         r_sync1 <= iIR;
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rpt_nxt   = r_rpt;
      w_clr_cnt   = 1'b0;
      w_idx_clr   = 1'b0;
      w_store     = 1'b0;
      w_bit       = 1'b0;
      w_load      = 1'b0;
      w_fv        = 1'b0;
      w_rp        = 1'b0;
      w_err       = 1'b0;
      w_code      = 3'd0;

      if ((r_state != IDLE) && (r_cnt >= CNT_MAX)) begin
         w_err  = 1'b1;
         w_code = 3'd4;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_nedge) begin
                  w_state_nxt = LEAD_LO;
                  w_clr_cnt   = 1'b1;
                  w_rpt_nxt   = 1'b0;
               end
            end
            LEAD_LO: begin
               if (w_pedge) begin
                  if (w_w9000) begin
                     w_state_nxt = LEAD_HI;
                     w_clr_cnt   = 1'b1;
                  end else begin
                     w_err  = 1'b1;
                     w_code = 3'd1;
                  end
               end
            end
            LEAD_HI: begin
               if (w_nedge) begin
                  if (w_w4500) begin
                     w_state_nxt = BIT_LO;
                     w_clr_cnt   = 1'b1;
                     w_idx_clr   = 1'b1;
                  end else if (REPEAT_EN && w_w2250) begin
                     w_state_nxt = STOP_LO;
                     w_clr_cnt   = 1'b1;
                     w_rpt_nxt   = 1'b1;
                  end else begin
                     w_err  = 1'b1;
                     w_code = 3'd2;
                  end
               end
            end
            BIT_LO: begin
               if (w_pedge) begin
                  if (w_w560) begin
                     w_state_nxt = BIT_HI;
                     w_clr_cnt   = 1'b1;
                  end else begin
                     w_err  = 1'b1;
                     w_code = 3'd3;
                  end
               end
            end
            BIT_HI: begin
               if (w_nedge) begin
                  if (w_w560 || w_w1690) begin
                     w_store     = 1'b1;
                     w_bit       = w_w1690;
                     w_clr_cnt   = 1'b1;
                     w_state_nxt = (r_idx == 5'd31) ? STOP_LO : BIT_LO;
                  end else begin
                     w_err  = 1'b1;
                     w_code = 3'd3;
                  end
               end
            end
            STOP_LO: begin
               if (w_pedge) begin
                  w_state_nxt = IDLE;
                  if (!w_w560) begin
                     w_err  = 1'b1;
                     w_code = 3'd3;
                  end else if (r_rpt) begin
                     if (r_last_ok) begin
                        w_rp = 1'b1;
                     end else begin
                        w_err  = 1'b1;
                        w_code = 3'd6;
                     end
                  end else if (CHECK_INV && (r_shift[31:24] != ~r_shift[23:16])) begin
                     w_err  = 1'b1;
                     w_code = 3'd5;
                  end else begin
                     w_fv   = 1'b1;
                     w_load = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end

      if (w_err) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt          <= '0;
         r_idx          <= '0;
         r_shift        <= '0;
         r_rpt          <= 1'b0;
         r_last_ok      <= 1'b0;
         r_frame_valid  <= 1'b0;
         r_repeat_pulse <= 1'b0;
         r_err          <= 1'b0;
         r_err_code     <= '0;
         r_addr         <= '0;
         r_data         <= '0;
      end else begin
         if (w_clr_cnt) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_idx_clr) begin
            r_idx <= '0;
         end else if (w_store && (r_idx != 5'd31)) begin
            r_idx <= r_idx + 1'b1;
         end

         if (w_store) begin
            r_shift[r_idx] <= w_bit;
         end

         r_rpt          <= w_rpt_nxt;
         r_frame_valid  <= w_fv;
         r_repeat_pulse <= w_rp;
         r_err          <= w_err;

         if (w_err) begin
            r_err_code <= w_code;
            r_last_ok  <= 1'b0;
         end else if (w_fv) begin
            r_last_ok  <= 1'b1;
         end

         if (w_load) begin
            r_addr <= r_shift[15:0];
            r_data <= r_shift[31:16];
         end
      end
   end

   assign frame_valid  = r_frame_valid;
   assign repeat_pulse = r_repeat_pulse;
   assign err          = r_err;
   assign err_code     = r_err_code;
   assign ir_addr      = r_addr;
   assign ir_data      = r_data;

endmodule

// File: tb/tb_ir_nec_rx.sv
`timescale 1ns/1ps
// tb_ir_nec_rx -- self-checking bench for ir_nec_rx.
//
// Three receivers share one IR waveform driven in real time:
//   A: 100 kHz clock, inverse check on
//   B: 100 kHz clock, inverse check off
//   C: 135 kHz clock (27 MHz / 200), clock only running for tolerance rows
// Scaled clocks keep a frame near 7k cycles while leaving enough counts per
// 560 us pulse that a +/-20% edge is not lost to integer truncation.
module tb_ir_nec_rx;

   localparam int unsigned HZ_A = 100000;
   localparam int unsigned HZ_C = 135000;
   localparam real TA_NS = 1.0e9 / HZ_A;
   localparam real TC_NS = 1.0e9 / HZ_C;

   logic clk_a   = 1'b0;
   logic clk_c   = 1'b0;
   logic c_run   = 1'b0;
   logic reset_n = 1'b1;
   logic iIR     = 1'b1;

   logic        fv_a, rp_a, er_a, fv_b, rp_b, er_b, fv_c, rp_c, er_c;
   logic [2:0]  code_a, code_b, code_c;
   logic [15:0] addr_a, data_a, addr_b, data_b, addr_c, data_c;

   always #(TA_NS / 2.0) clk_a = ~clk_a;
   always begin
      #(TC_NS / 2.0);
      if (c_run) clk_c = ~clk_c;
   end

   ir_nec_rx #(.CLK_HZ(HZ_A)) u_a (
      .clk(clk_a), .reset_n(reset_n), .iIR(iIR),
      .frame_valid(fv_a), .repeat_pulse(rp_a), .ir_addr(addr_a), .ir_data(data_a),
      .err(er_a), .err_code(code_a));

   ir_nec_rx #(.CLK_HZ(HZ_A), .CHECK_INV(1'b0)) u_b (
      .clk(clk_a), .reset_n(reset_n), .iIR(iIR),
      .frame_valid(fv_b), .repeat_pulse(rp_b), .ir_addr(addr_b), .ir_data(data_b),
      .err(er_b), .err_code(code_b));

   ir_nec_rx #(.CLK_HZ(HZ_C)) u_c (
      .clk(clk_c), .reset_n(reset_n), .iIR(iIR),
      .frame_valid(fv_c), .repeat_pulse(rp_c), .ir_addr(addr_c), .ir_data(data_c),
      .err(er_c), .err_code(code_c));

   // High-cycle counters per receiver; a stretched pulse counts more than once.
   int n_fv[3], n_rp[3], n_er[3];
   int s_fv[3], s_rp[3], s_er[3];

   always @(negedge clk_a) begin
      if (fv_a) n_fv[0] = n_fv[0] + 1;
      if (rp_a) n_rp[0] = n_rp[0] + 1;
      if (er_a) n_er[0] = n_er[0] + 1;
      if (fv_b) n_fv[1] = n_fv[1] + 1;
      if (rp_b) n_rp[1] = n_rp[1] + 1;
      if (er_b) n_er[1] = n_er[1] + 1;
   end

   always @(negedge clk_c) begin
      if (fv_c) n_fv[2] = n_fv[2] + 1;
      if (rp_c) n_rp[2] = n_rp[2] + 1;
      if (er_c) n_er[2] = n_er[2] + 1;
   end

   typedef enum int {K_FRAME, K_REPEAT, K_SHORT_LEAD, K_LONG_BIT, K_STUCK, K_LEAD_HI} kind_t;

   typedef struct {
      int          fv;
      int          rp;
      int          er;
      logic [2:0]  code;
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   typedef struct {
      string       name;
      kind_t       kind;
      int          lead_pct;
      int          pct;
      logic [31:0] bits;
      logic        c_chk;
      exp_t        ea;
      exp_t        eb;
      exp_t        ec;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic exp_t mk(input int fv, input int rp, input int er,
                               input logic [2:0] code, input logic [15:0] addr,
                               input logic [15:0] data);
      exp_t e;
      e.fv = fv; e.rp = rp; e.er = er; e.code = code; e.addr = addr; e.data = data;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_dut(input string vname, input int d, input exp_t e);
      string       tag;
      logic [2:0]  code;
      logic [15:0] addr, data;
      case (d)
         0: begin tag = "A"; code = code_a; addr = addr_a; data = data_a; end
         1: begin tag = "B"; code = code_b; addr = addr_b; data = data_b; end
         default: begin tag = "C"; code = code_c; addr = addr_c; data = data_c; end
      endcase
      chk({vname, "/", tag, "/frame_valid_cycles"}, 32'(n_fv[d] - s_fv[d]), 32'(e.fv));
      chk({vname, "/", tag, "/repeat_cycles"},      32'(n_rp[d] - s_rp[d]), 32'(e.rp));
      chk({vname, "/", tag, "/err_cycles"},         32'(n_er[d] - s_er[d]), 32'(e.er));
      chk({vname, "/", tag, "/err_code"},           32'(code), 32'(e.code));
      chk({vname, "/", tag, "/ir_addr"},            32'(addr), 32'(e.addr));
      chk({vname, "/", tag, "/ir_data"},            32'(data), 32'(e.data));
   endtask

   task automatic snapshot();
      for (int d = 0; d < 3; d++) begin
         s_fv[d] = n_fv[d];
         s_rp[d] = n_rp[d];
         s_er[d] = n_er[d];
      end
   endtask

   task automatic hold(input logic v, input real us);
      iIR = v;
      #(us * 1000.0);
   endtask

   task automatic send_frame(input logic [31:0] bits, input int lead_pct, input int pct);
      real s;
      s = pct / 100.0;
      hold(1'b0, 9000.0 * lead_pct / 100.0);
      hold(1'b1, 4500.0 * s);
      for (int i = 0; i < 32; i++) begin
         hold(1'b0, 560.0 * s);
         hold(1'b1, (bits[i] ? 1690.0 : 560.0) * s);
      end
      hold(1'b0, 560.0 * s);
      iIR = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      c_run = v.c_chk;
      hold(1'b1, 200.0);
      snapshot();
      case (v.kind)
         K_FRAME:      send_frame(v.bits, v.lead_pct, v.pct);
         K_REPEAT:     begin hold(1'b0, 9000.0); hold(1'b1, 2250.0); hold(1'b0, 560.0); end
         K_SHORT_LEAD: hold(1'b0, 6000.0);
         K_LONG_BIT:   begin
                          hold(1'b0, 9000.0); hold(1'b1, 4500.0);
                          hold(1'b0, 560.0);  hold(1'b1, 1200.0); hold(1'b0, 560.0);
                       end
         K_STUCK:      begin hold(1'b0, 9000.0); hold(1'b1, 4500.0); hold(1'b0, 12000.0); end
         default:      begin
                          hold(1'b0, 9000.0 * v.lead_pct / 100.0);
                          hold(1'b1, 4500.0 * v.pct / 100.0);
                          hold(1'b0, 560.0 * v.pct / 100.0);
                       end
      endcase
      hold(1'b1, 2000.0);
      @(negedge clk_a);
      check_dut(v.name, 0, v.ea);
      check_dut(v.name, 1, v.eb);
      if (v.c_chk) begin
         @(negedge clk_c);
         check_dut(v.name, 2, v.ec);
      end
   endtask

   localparam int NV = 10;
   vec_t tbl[NV];
   vec_t post;

   initial begin
      #1.5e9;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t z;
      logic [31:0] f1;
      z  = mk(0, 0, 0, 3'd0, 16'h0000, 16'h0000);
      f1 = 32'hBA45_00FF;

      tbl[0] = '{"rpt_after_rst", K_REPEAT, 100, 100, 32'h0, 1'b0,
                 mk(0,0,1,3'd6,16'h0000,16'h0000), mk(0,0,1,3'd6,16'h0000,16'h0000), z};
      tbl[1] = '{"frame_nom", K_FRAME, 100, 100, f1, 1'b0,
                 mk(1,0,0,3'd6,16'h00FF,16'hBA45), mk(1,0,0,3'd6,16'h00FF,16'hBA45), z};
      tbl[2] = '{"repeat", K_REPEAT, 100, 100, 32'h0, 1'b0,
                 mk(0,1,0,3'd6,16'h00FF,16'hBA45), mk(0,1,0,3'd6,16'h00FF,16'hBA45), z};
      tbl[3] = '{"bad_inverse", K_FRAME, 100, 100, 32'hBB45_00FF, 1'b0,
                 mk(0,0,1,3'd5,16'h00FF,16'hBA45), mk(1,0,0,3'd6,16'h00FF,16'hBB45), z};
      tbl[4] = '{"lead_6ms", K_SHORT_LEAD, 100, 100, 32'h0, 1'b0,
                 mk(0,0,1,3'd1,16'h00FF,16'hBA45), mk(0,0,1,3'd1,16'h00FF,16'hBB45), z};
      tbl[5] = '{"bit_hi_1200", K_LONG_BIT, 100, 100, 32'h0, 1'b0,
                 mk(0,0,1,3'd3,16'h00FF,16'hBA45), mk(0,0,1,3'd3,16'h00FF,16'hBB45), z};
      tbl[6] = '{"stuck_low", K_STUCK, 100, 100, 32'h0, 1'b0,
                 mk(0,0,1,3'd4,16'h00FF,16'hBA45), mk(0,0,1,3'd4,16'h00FF,16'hBB45), z};
      tbl[7] = '{"tol_minus20", K_FRAME, 80, 80, 32'hF00F_1234, 1'b1,
                 mk(1,0,0,3'd4,16'h1234,16'hF00F), mk(1,0,0,3'd4,16'h1234,16'hF00F),
                 mk(1,0,0,3'd0,16'h1234,16'hF00F)};
      // Leader low stays nominal: +20% of 9 ms would exceed the 10 ms timeout.
      tbl[8] = '{"tol_plus20", K_FRAME, 100, 120, 32'h7E81_A55A, 1'b1,
                 mk(1,0,0,3'd4,16'hA55A,16'h7E81), mk(1,0,0,3'd4,16'hA55A,16'h7E81),
                 mk(1,0,0,3'd0,16'hA55A,16'h7E81)};
      tbl[9] = '{"tol_plus30", K_LEAD_HI, 100, 130, 32'h0, 1'b1,
                 mk(0,0,1,3'd2,16'hA55A,16'h7E81), mk(0,0,1,3'd2,16'hA55A,16'h7E81),
                 mk(0,0,1,3'd2,16'hA55A,16'h7E81)};
      post   = '{"frame_after_rst", K_FRAME, 100, 100, f1, 1'b0,
                 mk(1,0,0,3'd0,16'h00FF,16'hBA45), mk(1,0,0,3'd0,16'h00FF,16'hBA45), z};

      // Reset state.
      #1000;
      reset_n = 1'b0;
      #50000;
      @(negedge clk_a);
      chk("rst/A/frame_valid", 32'(fv_a), 32'd0);
      chk("rst/A/repeat",      32'(rp_a), 32'd0);
      chk("rst/A/err",         32'(er_a), 32'd0);
      chk("rst/B/frame_valid", 32'(fv_b), 32'd0);
      chk("rst/B/err",         32'(er_b), 32'd0);
      chk("rst/C/err",         32'(er_c), 32'd0);
      snapshot();
      check_dut("rst", 0, z);
      check_dut("rst", 1, z);
      check_dut("rst", 2, z);
      reset_n = 1'b1;
      hold(1'b1, 500.0);

      for (int i = 0; i < NV; i++) begin
         apply(tbl[i]);
      end
      c_run = 1'b0;

      // Reset pulsed during bit 17 high: no pulse, outputs cleared, then a
      // fresh frame must decode normally.
      hold(1'b1, 500.0);
      snapshot();
      hold(1'b0, 9000.0);
      hold(1'b1, 4500.0);
      for (int i = 0; i < 17; i++) begin
         hold(1'b0, 560.0);
         hold(1'b1, f1[i] ? 1690.0 : 560.0);
      end
      hold(1'b0, 560.0);
      hold(1'b1, 200.0);
      reset_n = 1'b0;
      #50000;
      reset_n = 1'b1;
      hold(1'b1, 12000.0);
      @(negedge clk_a);
      check_dut("rst_bit17", 0, z);
      check_dut("rst_bit17", 1, z);

      apply(post);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz for all timing windows.
REQ-002 SHALL have parameter TOL_PCT, default 25, symmetric tolerance in percent applied to every nominal duration.
REQ-003 SHALL have parameter CHECK_INV, default 1, enabling the command-inverse check.
REQ-004 SHALL have parameter REPEAT_EN, default 1, enabling NEC repeat-code recognition.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port iIR, input, 1, raw asynchronous demodulated IR (idle high, burst low).
REQ-008 SHALL have port frame_valid, output, 1, one-cycle pulse on an accepted frame.
REQ-009 SHALL have port repeat_pulse, output, 1, one-cycle pulse on an accepted repeat code.
REQ-010 SHALL have port ir_addr, output, 16, frame bits 15:0 of the last accepted frame.
REQ-011 SHALL have port ir_data, output, 16, frame bits 31:16 of the last accepted frame.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on any rejected frame.
REQ-013 SHALL have port err_code, output, 3, cause of the last err pulse, held until the next err.

Function
REQ-014 SHALL synchronise iIR through two flops, then register once more for edge detection; nedge = falling, pedge = rising.
REQ-015 SHALL derive windows as N = CLK_HZ*us/1e6, accept when N*(100-TOL_PCT)/100 < count < N*(100+TOL_PCT)/100; nominals: 9000, 4500, 2250, 560, 1690 us.
REQ-016 SHALL size the duration counter by $clog2 of the 10 ms count, saturating at its maximum, cleared on every accepted edge.
REQ-017 SHALL implement states IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP_LO.
REQ-018 IDLE: on nedge go to LEAD_LO, counter cleared.
REQ-019 LEAD_LO: on pedge with 9000 window go to LEAD_HI, else error code 1.
REQ-020 LEAD_HI: on nedge with 4500 window go to BIT_LO with bit index 0; with 2250 window and REPEAT_EN=1 go to STOP_LO flagged repeat; otherwise error code 2.
REQ-021 BIT_LO: on pedge with 560 window go to BIT_HI, else error code 3.
REQ-022 BIT_HI: on nedge store 0 (560 window) or 1 (1690 window) at the current index, LSB first; other durations give error code 3; after index 31 go to STOP_LO, else back to BIT_LO.
REQ-023 STOP_LO: on pedge with 560 window finish the frame or repeat, else error code 3.
REQ-024 Frame finish: if CHECK_INV=1 and bits 31:24 differ from ~bits 23:16, error code 5; otherwise load ir_addr/ir_data from the shift register and pulse frame_valid.
REQ-025 Repeat finish: pulse repeat_pulse only if last_ok is set, with ir_addr/ir_data unchanged; if last_ok is clear, error code 6.
REQ-026 last_ok SHALL set on every frame_valid and clear on any err.
REQ-027 In any non-IDLE state, if the counter reaches 10 ms without an edge: error code 4.
REQ-028 Every error SHALL pulse err for one cycle, update err_code, and return to IDLE; no partial frame SHALL reach ir_addr/ir_data.
REQ-029 frame_valid, repeat_pulse and err SHALL assert exactly one clk after the qualifying edge-detect cycle and are mutually exclusive.
REQ-030 Bit index counter SHALL be 5 bits, with no wrap beyond 31.

Reset
REQ-031 On reset_n low, all flops clear asynchronously: state IDLE, outputs 0, err_code 0, last_ok 0, counter 0; sync flops reset to 1 (idle line).
REQ-032 Reset deasserted mid-frame SHALL leave the block in IDLE, waiting for a fresh leader.

Verification
REQ-033 Nominal frame with addr 0x00FF, cmd 0x45 (data 0xBA45) -> frame_valid single pulse, ir_addr=0x00FF, ir_data=0xBA45, err=0.
REQ-034 Repeat code (9 ms/2.25 ms/560 us) after that frame -> repeat_pulse, outputs unchanged; repeat issued straight after reset -> err, err_code=6.
REQ-035 Frame with cmd 0x45, inverse 0xBB, CHECK_INV=1 -> err, err_code=5, outputs hold previous values; same frame with CHECK_INV=0 -> frame_valid.
REQ-036 Leader low of 6 ms -> err, err_code=1; bit-high of 1.2 ms -> err code 3; line stuck low 12 ms after leader -> err code 4.
REQ-037 All durations at +/-20% with TOL_PCT=25 -> accepted; at +30% -> rejected; also rerun at CLK_HZ=27000000.
REQ-038 reset_n pulsed low at bit 17 -> no output pulse; the next full frame decodes correctly.
